// File: rtl/visu_pkg.sv
// Shared types and constants for the audio-reactive circle visualiser.
// The pulse controller and its abs helper both import this package.
package visu_pkg;

    localparam int RADIUS_OFF_W = 5;
    localparam int PEAK_W       = 15;
    localparam int DECAY_CNT_W  = 4;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        LATCH = 2'd1,
        APPLY = 2'd2
    } state_t;

    // Red ramps with the radius offset; blue is its complement so the circle shifts blue->red.
    function automatic logic [7:0] color_red(input logic [RADIUS_OFF_W-1:0] off);
        return {off, 3'b000};
    endfunction

    function automatic logic [7:0] color_blue(input logic [RADIUS_OFF_W-1:0] off);
        return 8'hFF - {off, 3'b000};
    endfunction

endpackage

// File: rtl/abs_sat16.sv
// Saturating absolute value of a signed 16-bit sample, 15-bit magnitude out.
// The most negative input maps to the largest positive magnitude.
module abs_sat16
    import visu_pkg::*;
(
    input  logic [15:0]       i_x,
    output logic [PEAK_W-1:0] o_abs
);

    logic [PEAK_W-1:0] w_neg;
    logic              w_is_min;

    // Low 15 bits of the two's complement negation only depend on the low 15 input bits.
    assign w_neg    = (~i_x[PEAK_W-1:0]) + 15'd1;
    assign w_is_min = (i_x == 16'h8000);

    always_comb begin
        o_abs = i_x[PEAK_W-1:0];
        if (w_is_min) begin
            o_abs = 15'h7FFF;
        end else if (i_x[15]) begin
            o_abs = w_neg;
        end
    end

endmodule

// File: rtl/circle_pulse_ctrl.sv
// Per-frame audio peak detector driving circle radius offset and colour,
// with instant attack, slow frame-based decay, and tear-free registered outputs.
module circle_pulse_ctrl
    import visu_pkg::*;
#(
    parameter int         DECAY_FRAMES = 2,
    parameter logic [7:0] COLOR_G      = 8'd64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [15:0]             i_sample,
    input  logic                    i_sample_valid,
    input  logic                    i_frame_start,
    output logic [RADIUS_OFF_W-1:0] o_radius_off,
    output logic [7:0]              o_color_R,
    output logic [7:0]              o_color_G,
    output logic [7:0]              o_color_B,
    output logic                    o_update
);

    localparam logic [DECAY_CNT_W-1:0] DECAY_LIM = DECAY_CNT_W'(DECAY_FRAMES);

    state_t                  r_state;
    logic [PEAK_W-1:0]       r_peak;
    logic [PEAK_W-1:0]       r_peak_latched;
    logic [RADIUS_OFF_W-1:0] r_target;
    logic [RADIUS_OFF_W-1:0] r_offset;
    logic [DECAY_CNT_W-1:0]  r_decay_cnt;

    logic [PEAK_W-1:0]       w_abs;
    logic [RADIUS_OFF_W-1:0] w_target;
    logic [RADIUS_OFF_W-1:0] w_offset_next;
    logic [DECAY_CNT_W-1:0]  w_decay_next;
    logic [DECAY_CNT_W-1:0]  w_decay_inc;
    logic                    w_frame_accept;

    abs_sat16 u_abs (
        .i_x   (i_sample),
        .o_abs (w_abs)
    );

    // Top five magnitude bits select the radius offset; the low bits are dropped.
    assign w_target       = RADIUS_OFF_W'(r_peak_latched >> (PEAK_W - RADIUS_OFF_W));
    assign w_frame_accept = (r_state == ACCUM) && i_frame_start;
    assign w_decay_inc    = r_decay_cnt + 4'd1;

    always_comb begin
        w_offset_next = r_offset;
        w_decay_next  = r_decay_cnt;
        if (r_target > r_offset) begin
            w_offset_next = r_target;
            w_decay_next  = '0;
        end else if (w_decay_inc == DECAY_LIM) begin
            w_offset_next = (r_offset != '0) ? r_offset - 5'd1 : '0;
            w_decay_next  = '0;
        end else begin
            w_decay_next  = w_decay_inc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ACCUM;
            r_peak         <= '0;
            r_peak_latched <= '0;
            r_target       <= '0;
            r_offset       <= '0;
            r_decay_cnt    <= '0;
            o_radius_off   <= '0;
            o_color_R      <= 8'd0;
            o_color_G      <= COLOR_G;
            o_color_B      <= 8'hFF;
            o_update       <= 1'b0;
        end else begin
            o_update  <= 1'b0;
            o_color_G <= COLOR_G;

            // A sample coincident with the frame boundary belongs to the new frame.
            if (w_frame_accept) begin
                r_peak_latched <= r_peak;
                r_peak         <= i_sample_valid ? w_abs : '0;
            end else if (i_sample_valid && (w_abs > r_peak)) begin
                r_peak <= w_abs;
            end

            case (r_state)
                ACCUM: begin
                    if (i_frame_start) begin
                        r_state <= LATCH;
                    end
                end
                LATCH: begin
                    r_target <= w_target;
                    r_state  <= APPLY;
                end
                APPLY: begin
                    r_offset     <= w_offset_next;
                    r_decay_cnt  <= w_decay_next;
                    o_radius_off <= w_offset_next;
                    o_color_R    <= color_red(w_offset_next);
                    o_color_B    <= color_blue(w_offset_next);
                    o_update     <= 1'b1;
                    r_state      <= ACCUM;
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circle_pulse_ctrl.sv
// Directed bench for circle_pulse_ctrl: reset, attack, saturation, decay,
// same-cycle sample/frame boundary and reset abort, all with hand-computed values.
module tb_circle_pulse_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] sample;
    logic        sample_valid;
    logic        frame_start;
    logic [4:0]  radius_off;
    logic [7:0]  color_r;
    logic [7:0]  color_g;
    logic [7:0]  color_b;
    logic        update;

    int n_vec = 0;
    int n_err = 0;

    circle_pulse_ctrl #(
        .DECAY_FRAMES (2),
        .COLOR_G      (8'd64)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_sample       (sample),
        .i_sample_valid (sample_valid),
        .i_frame_start  (frame_start),
        .o_radius_off   (radius_off),
        .o_color_R      (color_r),
        .o_color_G      (color_g),
        .o_color_B      (color_b),
        .o_update       (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int off, input logic upd);
        check({tag, ".off"}, 32'(radius_off), 32'(off));
        check({tag, ".R"},   32'(color_r),    32'(off * 8));
        check({tag, ".G"},   32'(color_g),    32'd64);
        check({tag, ".B"},   32'(color_b),    32'(255 - off * 8));
        check({tag, ".upd"}, 32'(update),     32'(upd));
    endtask

    task automatic send(input logic [15:0] s);
        sample       = s;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        sample       = 16'd0;
    endtask

    // Frame pulse (optionally with a coincident sample); outputs expected 3 cycles later.
    task automatic do_frame(input string tag, input bit with_sample, input logic [15:0] s,
                            input int exp_off, input int prev_off);
        frame_start  = 1'b1;
        sample       = s;
        sample_valid = with_sample;
        step();
        frame_start  = 1'b0;
        sample_valid = 1'b0;
        sample       = 16'd0;
        check({tag, ".n1"}, 32'(update), 32'd0);
        step();
        check({tag, ".n2_off"}, 32'(radius_off), 32'(prev_off));
        check({tag, ".n2_upd"}, 32'(update), 32'd0);
        step();
        check_outputs({tag, ".n3"}, exp_off, 1'b1);
        step();
        check({tag, ".n4_upd"}, 32'(update), 32'd0);
        check({tag, ".n4_off"}, 32'(radius_off), 32'(exp_off));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_off;
        int prev;
        rst          = 1'b1;
        sample       = 16'd0;
        sample_valid = 1'b0;
        frame_start  = 1'b0;

        // Reset then idle
        do_reset();
        check_outputs("reset", 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_upd", 32'(update), 32'd0);
        end
        check_outputs("idle_end", 0, 1'b0);

        // Peak of 100, -20480, 5000 -> 20480 >> 10 = 20
        send(16'd100);
        send(16'hB000);
        send(16'd5000);
        do_frame("attack20", 1'b0, 16'd0, 20, 0);

        // Silent frames decay one step every two frames
        do_frame("decay1", 1'b0, 16'd0, 20, 20);
        do_frame("decay2", 1'b0, 16'd0, 19, 20);
        do_frame("decay3", 1'b0, 16'd0, 19, 19);
        do_frame("decay4", 1'b0, 16'd0, 18, 19);
        prev = 18;
        for (int j = 1; j <= 40; j++) begin
            exp_off = 18 - j / 2;
            if (exp_off < 0) exp_off = 0;
            do_frame("decay_run", 1'b0, 16'd0, exp_off, prev);
            prev = exp_off;
        end
        check("decay_floor", 32'(radius_off), 32'd0);

        // Saturation of the most negative sample
        do_reset();
        send(16'h8000);
        do_frame("sat_min", 1'b0, 16'd0, 31, 0);

        // Sample coincident with frame_start counts toward the next frame
        do_reset();
        do_frame("same_cyc_a", 1'b1, 16'd31744, 0, 0);
        do_frame("same_cyc_b", 1'b0, 16'd0, 31, 0);

        // Reset while in LATCH aborts the update
        do_reset();
        send(16'd30000);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_outputs("abort_rst", 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_upd", 32'(update), 32'd0);
        end
        do_frame("abort_next", 1'b0, 16'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
